// File: rtl/cmp_nibble_sequencer.sv
// Drives one external 4-bit cascadable magnitude comparator a nibble per clock (LSB first)
// and returns the registered greater/less/equal verdict of two wide unsigned operands.
module cmp_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a_in,
  input  logic [4*NIBBLES-1:0]   b_in,
  output logic [3:0]             cmp_a,
  output logic [3:0]             cmp_b,
  output logic                   cmp_gt_in,
  output logic                   cmp_lt_in,
  output logic                   cmp_eq_in,
  input  logic                   cmp_gt,
  input  logic                   cmp_lt,
  input  logic                   cmp_eq,
  output logic                   busy,
  output logic                   done,
  output logic                   result_gt,
  output logic                   result_lt,
  output logic                   result_eq,
  output logic                   err,
  output logic [1:0]             dbgState
);

  localparam int W = 4 * NIBBLES;

  // Handshake: start is a level request taken only on an edge where the block is IDLE
  // (busy low); while busy it is ignored, and done is a one-cycle strobe with results held after.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT        state;
  stateT        nextState;
  logic [W-1:0] aShadow;
  logic [W-1:0] bShadow;
  logic [3:0]   idx;
  logic [2:0]   cascade;
  logic [2:0]   resultReg;
  logic         errReg;
  logic [2:0]   captured;
  logic         capturedOneHot;
  logic         lastNibble;
  logic [3:0]   aNib;
  logic [3:0]   bNib;

  assign captured       = {cmp_gt, cmp_lt, cmp_eq};
  assign capturedOneHot = (captured == 3'b100) || (captured == 3'b010) || (captured == 3'b001);
  assign lastNibble     = (idx == 4'(NIBBLES - 1));
  assign aNib           = 4'(aShadow >> {idx, 2'b00});
  assign bNib           = 4'(bShadow >> {idx, 2'b00});

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    cmp_a     = 4'd0;
    cmp_b     = 4'd0;
    {cmp_gt_in, cmp_lt_in, cmp_eq_in} = 3'b001;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) nextState = RUN;
      RUN: begin
        busy  = 1'b1;
        cmp_a = aNib;
        cmp_b = bNib;
        {cmp_gt_in, cmp_lt_in, cmp_eq_in} = cascade;
        if (lastNibble) nextState = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // A malformed comparator triple is propagated untouched; err only records that it happened.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aShadow   <= '0;
      bShadow   <= '0;
      idx       <= '0;
      cascade   <= 3'b001;
      resultReg <= 3'b000;
      errReg    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          aShadow <= a_in;
          bShadow <= b_in;
          idx     <= '0;
          cascade <= 3'b001;
          errReg  <= 1'b0;
        end
        RUN: begin
          cascade <= captured;
          errReg  <= errReg | ~capturedOneHot;
          idx     <= idx + 4'd1;
          if (lastNibble) resultReg <= captured;
        end
        default: ;
      endcase
    end
  end

  assign {result_gt, result_lt, result_eq} = resultReg;
  assign err      = errReg;
  assign dbgState = state;

endmodule

// File: tb/tb_cmp_nibble_sequencer.sv
// Bench for cmp_nibble_sequencer: behavioural 4-bit comparator with fault injection,
// directed scenarios plus random operands checked against whole-word reference compares.
module tb_cmp_nibble_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [3:0]   cmp_a;
  logic [3:0]   cmp_b;
  logic         cmp_gt_in;
  logic         cmp_lt_in;
  logic         cmp_eq_in;
  logic         cmp_gt;
  logic         cmp_lt;
  logic         cmp_eq;
  logic         busy;
  logic         done;
  logic         result_gt;
  logic         result_lt;
  logic         result_eq;
  logic         err;
  logic [1:0]   dbgState;

  logic         injectZero;
  int           nCompared;
  int           nMismatched;
  logic [2:0]   prevRes;
  logic         prevErr;
  logic [3:0]   expQ[$];

  cmp_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_gt_in(cmp_gt_in), .cmp_lt_in(cmp_lt_in), .cmp_eq_in(cmp_eq_in),
    .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .busy(busy), .done(done),
    .result_gt(result_gt), .result_lt(result_lt), .result_eq(result_eq),
    .err(err), .dbgState(dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external 74x85-style comparator
  always_comb begin
    if (injectZero)         {cmp_gt, cmp_lt, cmp_eq} = 3'b000;
    else if (cmp_a > cmp_b) {cmp_gt, cmp_lt, cmp_eq} = 3'b100;
    else if (cmp_a < cmp_b) {cmp_gt, cmp_lt, cmp_eq} = 3'b010;
    else                    {cmp_gt, cmp_lt, cmp_eq} = {cmp_gt_in, cmp_lt_in, cmp_eq_in};
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Whole-word reference: a zeroed comparator output at nibble k wipes the cascade,
  // so only the nibbles above k can still decide the verdict.
  function automatic logic [3:0] refCompare(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input int faultIdx);
    logic [63:0] hiA;
    logic [63:0] hiB;
    if (faultIdx < 0) begin
      if (a > b)      return 4'b0100;
      else if (a < b) return 4'b0010;
      else            return 4'b0001;
    end
    hiA = 64'(a) >> (4 * (faultIdx + 1));
    hiB = 64'(b) >> (4 * (faultIdx + 1));
    if (hiA > hiB)      return 4'b1100;
    else if (hiA < hiB) return 4'b1010;
    else                return 4'b1000;
  endfunction

  function automatic logic [3:0] nibOf(input logic [W-1:0] v, input int k);
    return 4'(v >> (4 * k));
  endfunction

  task automatic checkIdle(input string tag);
    checkVal({tag, "_busy"}, 64'(busy), 64'd0);
    checkVal({tag, "_done"}, 64'(done), 64'd0);
    checkVal({tag, "_res"}, 64'({result_gt, result_lt, result_eq}), 64'(prevRes));
    checkVal({tag, "_err"}, 64'(err), 64'(prevErr));
    checkVal({tag, "_casc"}, 64'({cmp_gt_in, cmp_lt_in, cmp_eq_in}), 64'b001);
    checkVal({tag, "_nib"}, 64'({cmp_a, cmp_b}), 64'd0);
  endtask

  task automatic checkDone(input string tag);
    logic [3:0] e;
    e = expQ.pop_front();
    checkVal({tag, "_done"}, 64'(done), 64'd1);
    checkVal({tag, "_busy"}, 64'(busy), 64'd1);
    checkVal({tag, "_res"}, 64'({result_gt, result_lt, result_eq}), 64'(e[2:0]));
    checkVal({tag, "_err"}, 64'(err), 64'(e[3]));
    checkVal({tag, "_casc"}, 64'({cmp_gt_in, cmp_lt_in, cmp_eq_in}), 64'b001);
    prevRes = e[2:0];
    prevErr = e[3];
  endtask

  // One full operation; start/operand noise while busy must have no effect.
  task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int faultIdx);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    expQ.push_back(refCompare(a, b, faultIdx));
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      start      = 1'($urandom_range(0, 1));
      a_in       = W'($urandom);
      b_in       = W'($urandom);
      injectZero = (k == faultIdx);
      checkVal({tag, "_runBusy"}, 64'(busy), 64'd1);
      checkVal({tag, "_runDone"}, 64'(done), 64'd0);
      checkVal({tag, "_cmpA"}, 64'(cmp_a), 64'(nibOf(a, k)));
      checkVal({tag, "_cmpB"}, 64'(cmp_b), 64'(nibOf(b, k)));
      if (k == 0) begin
        checkVal({tag, "_casc0"}, 64'({cmp_gt_in, cmp_lt_in, cmp_eq_in}), 64'b001);
        checkVal({tag, "_errClr"}, 64'(err), 64'd0);
        checkVal({tag, "_resHeld"}, 64'({result_gt, result_lt, result_eq}), 64'(prevRes));
      end
      @(posedge clk); #1;
    end
    injectZero = 1'b0;
    checkDone(tag);
    start = 1'b0;
    @(posedge clk); #1;
    checkIdle({tag, "_after"});
  endtask

  initial begin
    int         faultIdx;
    int         r;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] mask;

    nCompared   = 0;
    nMismatched = 0;
    prevRes     = 3'b000;
    prevErr     = 1'b0;
    injectZero  = 1'b0;
    rst_n       = 1'b0;
    start       = 1'b0;
    a_in        = '0;
    b_in        = '0;
    repeat (3) @(posedge clk);
    #1;
    checkIdle("reset");
    checkVal("reset_state", 64'(dbgState), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    runOp("eq1234", 16'h1234, 16'h1234, -1);
    runOp("msbWins", 16'h8000, 16'h7FFF, -1);
    runOp("lsbDecides", 16'h1234, 16'h1235, -1);

    // back-to-back with start held high; operand changes while busy are ignored
    @(negedge clk);
    a_in = 16'h00F0; b_in = 16'h000F; start = 1'b1;
    expQ.push_back(refCompare(16'h00F0, 16'h000F, -1));
    @(posedge clk); #1;
    a_in = 16'h0001; b_in = 16'h0010;
    for (int k = 0; k < N; k++) begin
      checkVal("b2b1_cmpA", 64'(cmp_a), 64'(nibOf(16'h00F0, k)));
      @(posedge clk); #1;
    end
    expQ.push_back(refCompare(16'h0001, 16'h0010, -1));
    checkDone("b2b1");
    @(posedge clk); #1;
    checkVal("b2b_gapBusy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      checkVal("b2b2_busy", 64'(busy), 64'd1);
      checkVal("b2b2_cmpA", 64'(cmp_a), 64'(nibOf(16'h0001, k)));
      @(posedge clk); #1;
    end
    checkDone("b2b2");
    @(posedge clk); #1;
    checkIdle("b2b_end");

    // reset in the middle of a run
    runOp("preRst", 16'h9000, 16'h1000, -1);
    @(negedge clk);
    a_in = 16'h4321; b_in = 16'h1234; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    prevRes = 3'b000;
    prevErr = 1'b0;
    checkIdle("midRst");
    @(negedge clk);
    rst_n = 1'b1;
    runOp("postRst", 16'h4321, 16'h1234, -1);

    // comparator fault: err held through IDLE until the next accepted start
    runOp("fault1", 16'h5A5A, 16'h5A5A, 1);
    repeat (3) @(posedge clk);
    #1;
    checkIdle("faultHold");
    runOp("faultClr", 16'h0F00, 16'h0E00, -1);

    // random operands, some sharing upper nibbles, occasional injected faults
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      r  = $urandom_range(0, 3);
      if (r == 0)      rb = W'($urandom);
      else if (r == 1) rb = ra;
      else begin
        mask = W'((64'd1 << (4 * $urandom_range(1, N))) - 1);
        rb   = (ra & ~mask) | (W'($urandom) & mask);
      end
      faultIdx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      runOp("rand", ra, rb, faultIdx);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    checkVal("expQ_empty", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
